// File: rtl/ins_wb.sv
// Commit/write-back stage: captures one request set, optionally waits on the memory write bus, then commits regfile/PC.
// Latency: done 1 cycle after accept (no store) or after ack/timeout; op is ignored while busy, no other backpressure.
module ins_wb #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        op,
  input  logic        reg_w_op,
  input  logic [4:0]  reg_w_reg_idx,
  input  logic [31:0] reg_w_reg_val,
  input  logic        mem_w_op,
  input  logic [31:0] mem_w_mem_addr,
  input  logic [31:0] mem_w_mem_val,
  input  logic        reg_pc_w_op,
  input  logic [31:0] reg_pc_w_val,
  output logic        rf_w_en,
  output logic [4:0]  rf_w_idx,
  output logic [31:0] rf_w_val,
  output logic        bus_w_req,
  output logic [31:0] bus_w_addr,
  output logic [31:0] bus_w_val,
  input  logic        bus_w_ack,
  output logic [31:0] pc_val,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;

  logic        cap_reg_op_q, cap_reg_op_d;
  logic [4:0]  cap_reg_idx_q, cap_reg_idx_d;
  logic [31:0] cap_reg_val_q, cap_reg_val_d;
  logic [31:0] cap_mem_addr_q, cap_mem_addr_d;
  logic [31:0] cap_mem_val_q, cap_mem_val_d;
  logic        cap_pc_op_q, cap_pc_op_d;
  logic [31:0] cap_pc_tgt_q, cap_pc_tgt_d;

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    err_d          = err_q;
    cap_reg_op_d   = cap_reg_op_q;
    cap_reg_idx_d  = cap_reg_idx_q;
    cap_reg_val_d  = cap_reg_val_q;
    cap_mem_addr_d = cap_mem_addr_q;
    cap_mem_val_d  = cap_mem_val_q;
    cap_pc_op_d    = cap_pc_op_q;
    cap_pc_tgt_d   = cap_pc_tgt_q;

    case (state_q)
      IDLE: begin
        if (op) begin
          cap_reg_op_d   = reg_w_op;
          cap_reg_idx_d  = reg_w_reg_idx;
          cap_reg_val_d  = reg_w_reg_val;
          cap_mem_addr_d = mem_w_mem_addr;
          cap_mem_val_d  = mem_w_mem_val;
          cap_pc_op_d    = reg_pc_w_op;
          cap_pc_tgt_d   = reg_pc_w_val;
          cnt_d          = 8'd0;
          state_d        = mem_w_op ? MEM : COMMIT;
        end
      end
      MEM: begin
        cnt_d = cnt_inc;
        // An ack landing on the limit edge wins over the timeout.
        if (bus_w_ack) begin
          state_d = COMMIT;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_d = COMMIT;
          err_d   = 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (cap_pc_op_q) begin
          pc_d = {cap_pc_tgt_q[31:2], 2'b00};
          if (cap_pc_tgt_q[1:0] != 2'b00) begin
            err_d = 1'b1;
          end
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      pc_q           <= RESET_PC;
      err_q          <= 1'b0;
      cap_reg_op_q   <= 1'b0;
      cap_reg_idx_q  <= 5'd0;
      cap_reg_val_q  <= 32'd0;
      cap_mem_addr_q <= 32'd0;
      cap_mem_val_q  <= 32'd0;
      cap_pc_op_q    <= 1'b0;
      cap_pc_tgt_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pc_q           <= pc_d;
      err_q          <= err_d;
      cap_reg_op_q   <= cap_reg_op_d;
      cap_reg_idx_q  <= cap_reg_idx_d;
      cap_reg_val_q  <= cap_reg_val_d;
      cap_mem_addr_q <= cap_mem_addr_d;
      cap_mem_val_q  <= cap_mem_val_d;
      cap_pc_op_q    <= cap_pc_op_d;
      cap_pc_tgt_q   <= cap_pc_tgt_d;
    end
  end

  // Strobes decode straight from state so reset drops them without waiting for a clock.
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == COMMIT);
  assign bus_w_req  = (state_q == MEM);
  assign bus_w_addr = cap_mem_addr_q;
  assign bus_w_val  = cap_mem_val_q;
  assign rf_w_en    = (state_q == COMMIT) && cap_reg_op_q && (cap_reg_idx_q != 5'd0);
  assign rf_w_idx   = cap_reg_idx_q;
  assign rf_w_val   = cap_reg_val_q;
  assign pc_val     = pc_q;
  assign err        = err_q;

endmodule
